// File: rtl/e_mdu_ctrl.sv
// EX-stage multiply/divide sequencer: holds HI/LO, computes the result on acceptance,
// and commits it after a fixed latency while busy is high. MDU_MADD_EN adds madd/maddu.
module e_mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8
    } mdu_op_e;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [31:0]   hi, lo;
    logic [63:0]   pend;
    logic          pend_ok;
    logic [CW-1:0] count;

    logic          op_valid;
    logic          accept;
    logic [63:0]   prod_s, prod_u;
    logic          div_signed, neg_a, neg_b;
    logic [31:0]   dvd, dvs, dvs_safe, q_mag, r_mag, quot, rem;

    assign busy   = (count != '0);
    assign hi_out = hi;
    assign lo_out = lo;

    always_comb begin
        op_valid = 1'b0;
        case (mdu_op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: op_valid = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: op_valid = 1'b1;
`endif
            default: op_valid = 1'b0;
        endcase
    end

    assign accept = start && !busy && op_valid;

    assign prod_u = {32'd0, srca} * {32'd0, srcb};
    assign prod_s = {{32{srca[31]}}, srca} * {{32{srcb[31]}}, srcb};

    // Divide on magnitudes so 0x80000000 / -1 wraps cleanly; a zero divisor is
    // replaced by one only to keep the datapath defined, since that result is discarded.
    always_comb begin
        div_signed = (mdu_op == OP_DIV);
        neg_a      = div_signed & srca[31];
        neg_b      = div_signed & srcb[31];
        dvd        = neg_a ? -srca : srca;
        dvs        = neg_b ? -srcb : srcb;
        dvs_safe   = (dvs == 32'd0) ? 32'd1 : dvs;
        q_mag      = dvd / dvs_safe;
        r_mag      = dvd % dvs_safe;
        quot       = (neg_a ^ neg_b) ? -q_mag : q_mag;
        rem        = neg_a ? -r_mag : r_mag;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend    <= 64'd0;
            pend_ok <= 1'b0;
            count   <= '0;
        end else if (count != '0) begin
            count <= count - CW'(1);
            if (count == CW'(1) && pend_ok) begin
                hi <= pend[63:32];
                lo <= pend[31:0];
            end
        end else if (accept) begin
            case (mdu_op)
                OP_MULT: begin
                    pend    <= prod_s;
                    pend_ok <= 1'b1;
                    count   <= CW'(MULT_CYCLES);
                end
                OP_MULTU: begin
                    pend    <= prod_u;
                    pend_ok <= 1'b1;
                    count   <= CW'(MULT_CYCLES);
                end
                OP_DIV, OP_DIVU: begin
                    pend    <= {rem, quot};
                    pend_ok <= (srcb != 32'd0);
                    count   <= CW'(DIV_CYCLES);
                end
                OP_MTHI: hi <= srca;
                OP_MTLO: lo <= srca;
`ifdef MDU_MADD_EN
                // Accumulate onto the HI/LO seen at acceptance, wrapping at 64 bits.
                OP_MADD: begin
                    pend    <= {hi, lo} + prod_s;
                    pend_ok <= 1'b1;
                    count   <= CW'(MULT_CYCLES);
                end
                OP_MADDU: begin
                    pend    <= {hi, lo} + prod_u;
                    pend_ok <= 1'b1;
                    count   <= CW'(MULT_CYCLES);
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Self-checking bench for e_mdu_ctrl: directed cases plus random ops against a
// 64-bit arithmetic reference model. Define MDU_MADD_EN to also cover madd/maddu.
module tb_e_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    e_mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .mdu_op(mdu_op),
        .srca(srca),
        .srcb(srcb),
        .busy(busy),
        .hi_out(hi_out),
        .lo_out(lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: plain 64-bit arithmetic on the architectural HI/LO.
    task automatic model_op(input int op, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lat = 0;
        case (op)
            1: begin p = 64'(sa * sb); {m_hi, m_lo} = p; lat = MULT_N; end
            2: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; lat = MULT_N; end
            3: begin
                lat = DIV_N;
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            4: begin
                lat = DIV_N;
                if (b != 0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            5: m_hi = a;
            6: m_lo = a;
`ifdef MDU_MADD_EN
            7: begin p = 64'(sa * sb); {m_hi, m_lo} = {m_hi, m_lo} + p; lat = MULT_N; end
            8: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = {m_hi, m_lo} + p; lat = MULT_N; end
`endif
            default: lat = 0;
        endcase
    endtask

    // Issues one op at the current cycle (called #1 after an edge) and follows it to commit.
    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                          input string name);
        logic [31:0] old_hi, old_lo;
        int          lat, n;
        old_hi = m_hi;
        old_lo = m_lo;
        model_op(op, a, b, lat);
        start  = 1'b1;
        mdu_op = 4'(op);
        srca   = a;
        srcb   = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mdu_op = 4'd0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            checks++;
            if (hi_out !== old_hi || lo_out !== old_lo) begin
                errors++;
                $display("[TB] FAIL %s_hold: hi/lo=%h/%h expected %h/%h", name, hi_out, lo_out, old_hi, old_lo);
            end
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== lat) begin
            errors++;
            $display("[TB] FAIL %s_latency: busy cycles=%0d expected %0d", name, n, lat);
        end
        checks++;
        if (hi_out !== m_hi || lo_out !== m_lo) begin
            errors++;
            $display("[TB] FAIL %s_result: hi/lo=%h/%h expected %h/%h", name, hi_out, lo_out, m_hi, m_lo);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi_out, lo_out);
        end
    endtask

    task automatic test_mult();
        run_op(1, 32'hFFFFFFFF, 32'h00000002, "mult");
        checks++;
        if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFFE) begin
            errors++;
            $display("[TB] FAIL mult_const: hi/lo=%h/%h expected ffffffff/fffffffe", hi_out, lo_out);
        end
        run_op(2, 32'hFFFFFFFF, 32'h00000002, "multu");
        checks++;
        if (hi_out !== 32'h00000001 || lo_out !== 32'hFFFFFFFE) begin
            errors++;
            $display("[TB] FAIL multu_const: hi/lo=%h/%h expected 00000001/fffffffe", hi_out, lo_out);
        end
    endtask

    task automatic test_div();
        run_op(3, 32'hFFFFFFF9, 32'd2, "div");
        checks++;
        if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFFD) begin
            errors++;
            $display("[TB] FAIL div_const: hi/lo=%h/%h expected ffffffff/fffffffd", hi_out, lo_out);
        end
        run_op(4, 32'd7, 32'd2, "divu");
        checks++;
        if (hi_out !== 32'd1 || lo_out !== 32'd3) begin
            errors++;
            $display("[TB] FAIL divu_const: hi/lo=%h/%h expected 1/3", hi_out, lo_out);
        end
        run_op(6, 32'h1234, 32'd0, "mtlo");
        checks++;
        if (lo_out !== 32'h1234 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mtlo_const: lo=%h busy=%b expected 1234/0", lo_out, busy);
        end
        run_op(3, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
        checks++;
        if (hi_out !== 32'd0 || lo_out !== 32'h80000000) begin
            errors++;
            $display("[TB] FAIL div_ovf_const: hi/lo=%h/%h expected 0/80000000", hi_out, lo_out);
        end
    endtask

    task automatic test_div_by_zero();
        run_op(5, 32'hAA, 32'd0, "mthi");
        run_op(6, 32'hBB, 32'd0, "mtlo");
        run_op(3, 32'd100, 32'd0, "div0");
        checks++;
        if (hi_out !== 32'hAA || lo_out !== 32'hBB) begin
            errors++;
            $display("[TB] FAIL div0_keep: hi/lo=%h/%h expected aa/bb", hi_out, lo_out);
        end
        run_op(4, 32'hFFFFFFFF, 32'd0, "divu0");
    endtask

    task automatic test_ignored_start();
        logic [31:0] old_hi, old_lo;
        int          lat, n;
        old_hi = m_hi;
        old_lo = m_lo;
        model_op(1, 32'h1234, 32'h10, lat);
        start  = 1'b1;
        mdu_op = 4'd1;
        srca   = 32'h1234;
        srcb   = 32'h10;
        @(posedge clk);
        #1;
        mdu_op = 4'd5;
        srca   = 32'h55;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mdu_op = 4'd0;
        n = 1;
        while (busy === 1'b1 && n < 100) begin
            checks++;
            if (hi_out !== old_hi || lo_out !== old_lo) begin
                errors++;
                $display("[TB] FAIL ignored_hold: hi/lo=%h/%h expected %h/%h", hi_out, lo_out, old_hi, old_lo);
            end
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== lat) begin
            errors++;
            $display("[TB] FAIL ignored_latency: busy cycles=%0d expected %0d", n, lat);
        end
        checks++;
        if (hi_out !== m_hi || lo_out !== m_lo || hi_out === 32'h55) begin
            errors++;
            $display("[TB] FAIL ignored_result: hi/lo=%h/%h expected %h/%h", hi_out, lo_out, m_hi, m_lo);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        run_op(5, 32'h77, 32'd0, "pre_mthi");
        model_op(3, 32'd1000, 32'd7, lat);
        start  = 1'b1;
        mdu_op = 4'd3;
        srca   = 32'd1000;
        srcb   = 32'd7;
        @(posedge clk);
        #1;
        start  = 1'b0;
        mdu_op = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        checks++;
        if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midreset_state: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi_out, lo_out);
        end
        repeat (DIV_N + 3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midreset_nocommit: busy=%b hi=%h lo=%h expected 0/0/0", busy, hi_out, lo_out);
        end
    endtask

    task automatic test_invalid_codes();
        int codes[$];
        codes = '{0, 9, 10, 11, 12, 13, 14, 15};
`ifndef MDU_MADD_EN
        codes.push_back(7);
        codes.push_back(8);
`endif
        foreach (codes[i]) begin
            start  = 1'b1;
            mdu_op = 4'(codes[i]);
            srca   = $urandom;
            srcb   = $urandom;
            @(posedge clk);
            #1;
            start  = 1'b0;
            mdu_op = 4'd0;
            checks++;
            if (busy !== 1'b0 || hi_out !== m_hi || lo_out !== m_lo) begin
                errors++;
                $display("[TB] FAIL invalid_op%0d: busy=%b hi/lo=%h/%h expected 0 %h/%h",
                         codes[i], busy, hi_out, lo_out, m_hi, m_lo);
            end
        end
    endtask

`ifdef MDU_MADD_EN
    task automatic test_madd();
        run_op(5, 32'd0, 32'd0, "madd_mthi");
        run_op(6, 32'd5, 32'd0, "madd_mtlo");
        run_op(7, 32'd3, 32'd4, "madd");
        checks++;
        if (hi_out !== 32'd0 || lo_out !== 32'h11) begin
            errors++;
            $display("[TB] FAIL madd_const: hi/lo=%h/%h expected 0/11", hi_out, lo_out);
        end
        run_op(7, 32'hFFFFFFFF, 32'h00000020, "madd_neg");
        run_op(8, 32'hFFFFFFFF, 32'hFFFFFFFF, "maddu");
    endtask
`endif

    task automatic test_random();
        int          op;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
`ifdef MDU_MADD_EN
            op = $urandom_range(1, 8);
`else
            op = $urandom_range(1, 6);
`endif
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                3: b = -($urandom_range(1, 20));
                default: ;
            endcase
            run_op(op, a, b, "random");
        end
    endtask

    // Ops issued in the first cycle busy is low must be accepted without a gap.
    task automatic test_back_to_back();
        run_op(1, 32'd123456, 32'd789, "b2b_mult");
        run_op(4, 32'hDEADBEEF, 32'd1000, "b2b_divu");
        run_op(2, 32'hCAFEBABE, 32'h12345678, "b2b_multu");
        run_op(5, 32'h0F0F0F0F, 32'd0, "b2b_mthi");
        run_op(3, 32'h7FFFFFFF, 32'hFFFFFFFD, "b2b_div");
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        mdu_op = 4'd0;
        srca   = 32'd0;
        srcb   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_ignored_start();
        test_mid_reset();
        test_invalid_codes();
`ifdef MDU_MADD_EN
        test_madd();
`endif
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/e_mdu_ctrl.md
Name: e_mdu_ctrl

Overview:
- Multiply/divide sequencer in the EX stage, alongside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo requests and holds the architectural HI/LO registers.
- Models fixed multi-cycle latency by raising a busy flag, so hazard logic can stall later HI/LO users.
- The product/quotient is computed when the request is accepted; HI/LO commit only when the latency expires.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (and madd/maddu when enabled); must be >= 1.
- DIV_CYCLES, 10, busy duration for div/divu; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request valid this cycle.
- mdu_op  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu; other codes are none.
- srca  input  32  operand A (rs value).
- srcb  input  32  operand B (rt value).
- busy  output  1  high while a mult/div is in flight.
- hi_out  output  32  current HI register.
- lo_out  output  32  current LO register.

Behaviour:
- Reset:
  - Synchronous, active-high.
  - At the reset edge, HI=0, LO=0, cycle counter=0, busy=0 and the pending result is cleared.
  - Reset overrides start and any in-flight operation; an aborted op never commits.
- Acceptance:
  - An op is accepted at a rising edge when start=1, busy=0, reset=0 and mdu_op is a valid code.
  - start while busy=1 is ignored entirely, including mthi/mtlo. Upstream stall logic stalls on (start && mult/div op) || busy, so this case is a protocol error that is tolerated silently.
- mthi/mtlo:
  - Single cycle: HI (or LO) takes srca at the accepting edge.
  - busy stays 0.
- mult/multu:
  - 64-bit product computed from the operands sampled at acceptance: signed for mult, unsigned for multu.
  - Held in an internal pending register; counter loaded with MULT_CYCLES.
- div/divu:
  - Signed div truncates toward zero; the remainder takes the sign of the dividend.
  - Pending LO=quotient, HI=remainder; counter loaded with DIV_CYCLES.
  - divu is the same with unsigned operands.
- Divide by zero (srcb=0):
  - The op is still accepted and busy still lasts DIV_CYCLES.
  - At completion HI/LO keep their previous values (no commit).
- Counter and commit:
  - busy = (counter != 0), taken from the register, not combinational on start.
  - Counter decrements at each edge while nonzero.
  - At the edge where the counter goes 1 -> 0, {HI,LO} take the pending value. busy falls at that same edge, so the new HI/LO are visible in the first cycle with busy=0.
- Latency: busy is high for exactly N cycles after the accepting edge (N = MULT_CYCLES or DIV_CYCLES).
- hi_out/lo_out:
  - Reflect the registers directly.
  - Old values remain visible throughout busy.
- Back-to-back: a new op may be accepted in the first cycle busy=0 (the cycle after the commit edge).
- Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0, committed normally.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 7 (madd) computes {HI,LO} + signed(srca)*signed(srcb).
  - op 8 (maddu) computes {HI,LO} + unsigned(srca)*unsigned(srcb).
  - The sum wraps modulo 2^64.
  - The HI/LO values used are those at the accepting edge; busy lasts MULT_CYCLES.
- Not defined: codes 7 and 8 are treated as none (not accepted, no busy, no state change).

Test Plan:
- Signed mult: reset; start=1, mult, srca=0xFFFFFFFF, srcb=0x00000002 -> busy=1 for 5 cycles, HI/LO stay 0 during busy, then HI=0xFFFFFFFF, LO=0xFFFFFFFE when busy drops.
- Unsigned multu: multu with the same operands -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- Signed div: div srca=0xFFFFFFF9 (-7), srcb=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Unsigned divu and mtlo: divu 7/2 -> LO=3, HI=1. Then mtlo srca=0x1234 -> LO=0x1234 next cycle with busy staying 0.
- Divide by zero: mthi 0xAA, mtlo 0xBB; then div srcb=0 -> busy 10 cycles, HI=0xAA and LO=0xBB unchanged afterwards.
- Ignored start and mid-op reset:
  - During mult busy, pulse start with mthi 0x55 -> HI not 0x55 and mult commits normally.
  - Separately, assert reset 3 cycles into a div -> next cycle busy=0, HI=LO=0, and no commit occurs later.
- MDU_MADD_EN only: with HI=0, LO=5, madd 3*4 -> after 5 cycles LO=0x11, HI=0.
